// File: rtl/lsu_mem_bridge.sv
// Purpose: load/store bridge from the hart's memory stage to a req/gnt/rvalid data memory.
// Latency: 3 edges accept-to-response minimum (1 edge for traps); one access in flight.
// Backpressure: o_req_ready only in IDLE; response held in RESP until i_rsp_ready.
//
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_req_*  / o_req_ready            hart request (wen, byte addr, size, unsigned, right-justified wdata)
//   o_rsp_*  / i_rsp_ready            response (extended rdata, trap, err)
//   o_mem_*, i_mem_gnt                memory request, held stable until grant
//   i_mem_rvalid/rdata/err            memory response beat
module lsu_mem_bridge #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int GNT_TIMEOUT = 256
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_wen,
   input  logic [ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [1:0]              i_req_size,
   input  logic                    i_req_unsigned,
   input  logic [DATA_WIDTH-1:0]   i_req_wdata,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
   output logic                    o_rsp_trap,
   output logic                    o_rsp_err,
   output logic                    o_mem_req,
   input  logic                    i_mem_gnt,
   output logic [ADDR_WIDTH-1:0]   o_mem_addr,
   output logic                    o_mem_wen,
   output logic [DATA_WIDTH-1:0]   o_mem_wdata,
   output logic [DATA_WIDTH/8-1:0] o_mem_mask,
   input  logic                    i_mem_rvalid,
   input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
   input  logic                    i_mem_err
);

   localparam int MASK_W = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(MASK_W);
   localparam int CNT_W  = $clog2(GNT_TIMEOUT + 2);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_wen;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_size;
   logic                  r_uns;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_trap;
   logic                  r_err;

   logic                  w_in_mis;
   logic                  w_in_illegal;
   logic [OFF_W-1:0]      w_off;
   logic [OFF_W+2:0]      w_shamt;
   logic [7:0]            w_lanes;
   logic [15:0]           w_mask_wide;
   logic [DATA_WIDTH-1:0] w_rd_sh;
   logic [6:0]            w_nbits;
   logic [DATA_WIDTH-1:0] w_keep;
   logic                  w_sign;
   logic [DATA_WIDTH-1:0] w_ext;
   logic                  w_timeout;
   logic                  w_issue;

   // Alignment is checked on the incoming request so the trap decision is made at accept.
   always_comb begin
      w_in_mis = 1'b0;
      case (i_req_size)
         2'd1:    w_in_mis = i_req_addr[0];
         2'd2:    w_in_mis = |i_req_addr[1:0];
         2'd3:    w_in_mis = |i_req_addr[2:0];
         default: w_in_mis = 1'b0;
      endcase
   end
   assign w_in_illegal = (i_req_size == 2'd3) && (DATA_WIDTH == 32);

   assign w_off   = r_addr[OFF_W-1:0];
   assign w_shamt = {w_off, 3'b000};

   always_comb begin
      w_lanes = 8'h01;
      case (r_size)
         2'd0:    w_lanes = 8'h01;
         2'd1:    w_lanes = 8'h03;
         2'd2:    w_lanes = 8'h0F;
         default: w_lanes = 8'hFF;
      endcase
   end
   assign w_mask_wide = {8'h00, w_lanes} << w_off;

   // Load path: move the addressed lanes down to bit 0, keep 2^size bytes, extend.
   assign w_rd_sh = i_mem_rdata >> w_shamt;
   assign w_nbits = 7'd8 << r_size;
   // A 64-bit shift on a 32-bit bus yields 0, so w_keep saturates to all ones.
   assign w_keep  = ~({DATA_WIDTH{1'b1}} << w_nbits);

   always_comb begin
      w_sign = 1'b0;
      case (r_size)
         2'd0:    w_sign = w_rd_sh[7];
         2'd1:    w_sign = w_rd_sh[15];
         2'd2:    w_sign = w_rd_sh[31];
         default: w_sign = w_rd_sh[DATA_WIDTH-1];
      endcase
   end
   assign w_ext = (w_rd_sh & w_keep) | ((w_sign && !r_uns) ? ~w_keep : '0);

   // Timeout fires on the GNT_TIMEOUT-th ungranted ISSUE cycle; a grant in that cycle wins.
   assign w_timeout = (GNT_TIMEOUT != 0) && !i_mem_gnt &&
                      (r_cnt == CNT_W'(GNT_TIMEOUT - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_wen   <= 1'b0;
         r_addr  <= '0;
         r_size  <= 2'd0;
         r_uns   <= 1'b0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_trap  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_wen   <= i_req_wen;
                  r_addr  <= i_req_addr;
                  r_size  <= i_req_size;
                  r_uns   <= i_req_unsigned;
                  r_wdata <= i_req_wdata;
                  r_cnt   <= '0;
                  r_rdata <= '0;
                  r_err   <= 1'b0;
                  if (w_in_mis || w_in_illegal) begin
                     r_trap  <= 1'b1;
                     r_state <= S_RESP;
                  end else begin
                     r_trap  <= 1'b0;
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (i_mem_gnt) begin
                  r_state <= S_WAIT;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_state <= S_RESP;
               end else if (GNT_TIMEOUT != 0) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_WAIT: begin
               if (i_mem_rvalid) begin
                  r_err   <= i_mem_err;
                  r_rdata <= (i_mem_err || r_wen) ? '0 : w_ext;
                  r_state <= S_RESP;
               end
            end
            default: begin
               if (i_rsp_ready) begin
                  r_rdata <= '0;
                  r_trap  <= 1'b0;
                  r_err   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign w_issue = (r_state == S_ISSUE);

   assign o_req_ready = (r_state == S_IDLE);
   assign o_rsp_valid = (r_state == S_RESP);
   assign o_rsp_rdata = r_rdata;
   assign o_rsp_trap  = r_trap;
   assign o_rsp_err   = r_err;

   // Memory-side outputs are driven only while issuing so they read 0 elsewhere.
   assign o_mem_req   = w_issue;
   assign o_mem_addr  = w_issue ? {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign o_mem_wen   = w_issue && r_wen;
   assign o_mem_wdata = w_issue ? (r_wdata << w_shamt) : '0;
   assign o_mem_mask  = w_issue ? w_mask_wide[MASK_W-1:0] : '0;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Purpose: self-checking bench for lsu_mem_bridge, 32-bit and 64-bit instances side by side.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: grant, rvalid and rsp_ready delays are varied per transaction.
module tb_lsu_mem_bridge;

   localparam int TO = 4;

   typedef struct {
      bit          s64;
      bit          wen;
      logic [31:0] addr;
      logic [1:0]  size;
      bit          uns;
      logic [63:0] wdata;
      int          gd;      // ungranted ISSUE cycles before grant
      int          rd;      // WAIT cycles before rvalid
      int          yd;      // RESP cycles before rsp_ready
      logic [63:0] mrd;
      bit          merr;
      bit          e_trap;
      bit          e_err;
      logic [63:0] e_rdata;
      logic [7:0]  e_mask;
      logic [31:0] e_maddr;
      logic [63:0] e_mwdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0, req_wen = 1'b0, req_uns = 1'b0;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic [63:0] req_wdata = '0;
   logic        rsp_ready = 1'b0;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
   logic [63:0] mem_rdata = '0;

   logic        rr32, rv32, tr32, er32, mq32, mw32;
   logic [31:0] rd32, ma32, wd32;
   logic [3:0]  mk32;
   logic        rr64, rv64, tr64, er64, mq64, mw64;
   logic [63:0] rd64, wd64;
   logic [31:0] ma64;
   logic [7:0]  mk64;

   logic        v_req_ready, v_rsp_valid, v_trap, v_err, v_mem_req, v_mem_wen;
   logic [63:0] v_rdata, v_mwdata;
   logic [31:0] v_maddr;
   logic [7:0]  v_mask;

   int n_checks = 0;
   int n_fail   = 0;
   int cur      = 0;

   always #5 clk = ~clk;

   lsu_mem_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .GNT_TIMEOUT(TO)) u_dut32 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid && !sel), .o_req_ready(rr32),
      .i_req_wen(req_wen), .i_req_addr(req_addr), .i_req_size(req_size),
      .i_req_unsigned(req_uns), .i_req_wdata(req_wdata[31:0]),
      .o_rsp_valid(rv32), .i_rsp_ready(rsp_ready && !sel),
      .o_rsp_rdata(rd32), .o_rsp_trap(tr32), .o_rsp_err(er32),
      .o_mem_req(mq32), .i_mem_gnt(mem_gnt), .o_mem_addr(ma32), .o_mem_wen(mw32),
      .o_mem_wdata(wd32), .o_mem_mask(mk32),
      .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata[31:0]), .i_mem_err(mem_err));

   lsu_mem_bridge #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .GNT_TIMEOUT(TO)) u_dut64 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid && sel), .o_req_ready(rr64),
      .i_req_wen(req_wen), .i_req_addr(req_addr), .i_req_size(req_size),
      .i_req_unsigned(req_uns), .i_req_wdata(req_wdata),
      .o_rsp_valid(rv64), .i_rsp_ready(rsp_ready && sel),
      .o_rsp_rdata(rd64), .o_rsp_trap(tr64), .o_rsp_err(er64),
      .o_mem_req(mq64), .i_mem_gnt(mem_gnt), .o_mem_addr(ma64), .o_mem_wen(mw64),
      .o_mem_wdata(wd64), .o_mem_mask(mk64),
      .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .i_mem_err(mem_err));

   assign v_req_ready = sel ? rr64 : rr32;
   assign v_rsp_valid = sel ? rv64 : rv32;
   assign v_trap      = sel ? tr64 : tr32;
   assign v_err       = sel ? er64 : er32;
   assign v_mem_req   = sel ? mq64 : mq32;
   assign v_mem_wen   = sel ? mw64 : mw32;
   assign v_rdata     = sel ? rd64 : {32'h0, rd32};
   assign v_mwdata    = sel ? wd64 : {32'h0, wd32};
   assign v_maddr     = sel ? ma64 : ma32;
   assign v_mask      = sel ? mk64 : {4'h0, mk32};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL [%0d] %s: got %h expected %h", cur, name, act, exp);
      end
   endtask

   // Reference model built from byte-lane arithmetic on the access rules.
   function automatic void model(inout vec_t v);
      int nbw = v.s64 ? 8 : 4;
      int nb  = 1 << v.size;
      int off = int'(v.addr % nbw);
      bit tmo = (v.gd >= TO);
      v.e_trap   = ((v.addr % nb) != 0) || (v.size == 2'd3 && !v.s64);
      v.e_maddr  = v.addr - off;
      v.e_mask   = '0;
      v.e_mwdata = '0;
      v.e_rdata  = '0;
      v.e_err    = 1'b0;
      for (int i = 0; i < nb; i++)
         if (off + i < nbw) v.e_mask[off + i] = 1'b1;
      for (int i = 0; i + off < nbw; i++)
         v.e_mwdata[8*(i + off) +: 8] = v.wdata[8*i +: 8];
      if (!v.e_trap) begin
         if (tmo || v.merr) begin
            v.e_err = 1'b1;
         end else if (!v.wen) begin
            for (int i = 0; i < nb; i++)
               v.e_rdata[8*i +: 8] = v.mrd[8*(off + i) +: 8];
            if (!v.uns && v.e_rdata[8*nb - 1])
               for (int b = 8*nb; b < 8*nbw; b++) v.e_rdata[b] = 1'b1;
         end
      end
   endfunction

   // Runs one access end to end; all waits are fixed-length loops.
   task automatic do_txn(input vec_t v);
      bit tmo = 1'b0;
      sel       = v.s64;
      req_valid = 1'b1;
      req_wen   = v.wen;
      req_addr  = v.addr;
      req_size  = v.size;
      req_uns   = v.uns;
      req_wdata = v.wdata;
      @(negedge clk);
      chk("req_ready", v_req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (!v.e_trap) begin
         for (int c = 0; c < 64; c++) begin
            mem_gnt = (c == v.gd);
            @(negedge clk);
            chk("mem_req", v_mem_req, 1);
            chk("rsp_valid_issue", v_rsp_valid, 0);
            chk("mem_addr", v_maddr, v.e_maddr);
            chk("mem_mask", v_mask, v.e_mask);
            chk("mem_wdata", v_mwdata, v.e_mwdata);
            chk("mem_wen", v_mem_wen, v.wen);
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            if (c == v.gd) break;
            if (c == TO - 1) begin tmo = 1'b1; break; end
         end
         if (!tmo) begin
            for (int c = 0; c <= v.rd; c++) begin
               mem_rvalid = (c == v.rd);
               mem_rdata  = (c == v.rd) ? v.mrd : {$urandom, $urandom};
               mem_err    = (c == v.rd) ? v.merr : 1'b1;
               @(negedge clk);
               chk("mem_req_wait", v_mem_req, 0);
               chk("rsp_valid_wait", v_rsp_valid, 0);
               @(posedge clk); #1;
               mem_rvalid = 1'b0;
               mem_err    = 1'b0;
            end
         end
      end
      for (int c = 0; c <= v.yd; c++) begin
         rsp_ready  = (c == v.yd);
         mem_rvalid = 1'($urandom_range(0, 1));
         mem_gnt    = 1'($urandom_range(0, 1));
         mem_rdata  = {$urandom, $urandom};
         @(negedge clk);
         chk("rsp_valid", v_rsp_valid, 1);
         chk("rsp_trap", v_trap, v.e_trap);
         chk("rsp_err", v_err, v.e_err);
         chk("rsp_rdata", v_rdata, v.e_rdata);
         chk("mem_req_resp", v_mem_req, 0);
         chk("req_ready_resp", v_req_ready, 0);
         @(posedge clk); #1;
         rsp_ready  = 1'b0;
         mem_rvalid = 1'b0;
         mem_gnt    = 1'b0;
      end
      @(negedge clk);
      chk("idle_rsp_valid", v_rsp_valid, 0);
      chk("idle_req_ready", v_req_ready, 1);
      @(posedge clk); #1;
   endtask

   vec_t vecs[13];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //        s64 wen addr       sz uns wdata              gd  rd yd mrd                    merr trp err rdata                  mask   maddr      mwdata
      vecs[0]  = '{0, 0, 32'h1002, 1, 0, 64'h0,               0, 0, 0, 64'h8001_1234,          0, 0, 0, 64'hFFFF_8001,           8'h0C, 32'h1000, 64'h0};
      vecs[1]  = '{0, 1, 32'h2003, 0, 0, 64'hAB,              0, 0, 1, 64'h5555_5555,          0, 0, 0, 64'h0,                   8'h08, 32'h2000, 64'hAB00_0000};
      vecs[2]  = '{0, 0, 32'h1006, 2, 0, 64'h0,               0, 0, 0, 64'h0,                  0, 1, 0, 64'h0,                   8'h00, 32'h0,    64'h0};
      vecs[3]  = '{0, 0, 32'h1000, 3, 0, 64'h0,               0, 0, 0, 64'h0,                  0, 1, 0, 64'h0,                   8'h00, 32'h0,    64'h0};
      vecs[4]  = '{0, 0, 32'h3000, 2, 0, 64'h1234_5678,      99, 0, 5, 64'h0,                  0, 0, 1, 64'h0,                   8'h0F, 32'h3000, 64'h1234_5678};
      vecs[5]  = '{1, 0, 32'h14,   2, 1, 64'h0,               0, 0, 0, 64'h9000_0001_0000_0000, 0, 0, 0, 64'h9000_0001,          8'hF0, 32'h10,   64'h0};
      vecs[6]  = '{1, 0, 32'h14,   2, 1, 64'h0,               0, 0, 0, 64'h9000_0001_0000_0000, 1, 0, 1, 64'h0,                   8'hF0, 32'h10,   64'h0};
      vecs[7]  = '{1, 0, 32'h8,    3, 0, 64'h0,               1, 1, 0, 64'hFEDC_BA98_7654_3210, 0, 0, 0, 64'hFEDC_BA98_7654_3210, 8'hFF, 32'h8,    64'h0};
      vecs[8]  = '{1, 0, 32'h7,    0, 0, 64'h0,               0, 0, 0, 64'h80FF_0000_0000_0000, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 8'h80, 32'h0,    64'h0};
      vecs[9]  = '{1, 0, 32'h4,    3, 0, 64'h0,               0, 0, 0, 64'h0,                  0, 1, 0, 64'h0,                   8'h00, 32'h0,    64'h0};
      vecs[10] = '{1, 1, 32'h6,    1, 0, 64'h1234,            0, 0, 0, 64'h0,                  0, 0, 0, 64'h0,                   8'hC0, 32'h0,    64'h1234_0000_0000_0000};
      vecs[11] = '{0, 0, 32'h11,   0, 1, 64'h0,               3, 2, 0, 64'hDEAD_BEEF,          0, 0, 0, 64'hBE,                  8'h02, 32'h10,   64'h0};
      vecs[12] = '{1, 0, 32'h2A,   1, 1, 64'h0,               0, 2, 0, 64'h0000_0000_8001_0000, 0, 0, 0, 64'h8001,                8'h0C, 32'h28,   64'h0};

      // Reset state of both instances.
      #3;
      chk("rst32_req_ready", rr32, 1);
      chk("rst32_outs", {rv32, tr32, er32, mq32, mw32}, 0);
      chk("rst32_data", {rd32, ma32}, 0);
      chk("rst32_mem", {wd32, 28'h0, mk32}, 0);
      chk("rst64_req_ready", rr64, 1);
      chk("rst64_outs", {rv64, tr64, er64, mq64, mw64}, 0);
      chk("rst64_data", rd64 | wd64 | {ma64, 24'h0, mk64}, 0);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         cur = i;
         do_txn(vecs[i]);
      end

      // Asynchronous reset while waiting for the memory response.
      cur = 100;
      sel = 1'b0; req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h100; req_size = 2'd2;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("pre_rst_in_wait", {rv32, mq32, rr32}, 0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req_ready", rr32, 1);
      chk("arst_mem_req", mq32, 0);
      chk("arst_rsp", {rv32, tr32, er32}, 0);
      chk("arst_rdata", rd32, 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222; mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stray_rvalid_rsp", rv32, 0);
         chk("stray_gnt_idle", {mq32, rr32}, 1);
      end
      @(posedge clk); #1;

      // Randomised accesses against the model.
      for (int i = 0; i < 200; i++) begin
         vec_t v;
         cur = 1000 + i;
         v.s64   = 1'($urandom_range(0, 1));
         v.wen   = 1'($urandom_range(0, 1));
         v.size  = 2'($urandom_range(0, 3));
         v.addr  = $urandom;
         if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((32'd1 << v.size) - 32'd1);
         v.uns   = 1'($urandom_range(0, 1));
         v.wdata = {$urandom, $urandom};
         v.gd    = $urandom_range(0, 5);
         v.rd    = $urandom_range(0, 3);
         v.yd    = $urandom_range(0, 2);
         v.mrd   = {$urandom, $urandom};
         v.merr  = ($urandom_range(0, 7) == 0);
         model(v);
         if (!v.s64) v.wdata = {32'h0, v.wdata[31:0]};
         do_txn(v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
- Parametrised load/store bridge between the hart's execute/memory stage and a variable-latency data memory with a request/grant/response handshake.
- Successor to the combinational word-aligned masked dmem port: supports 32- or 64-bit data buses and byte/half/word/(dword) accesses.
- Performs misalignment trapping, byte-lane steering, sign/zero extension and grant timeout.
- One transaction in flight; the hart stalls on o_req_ready/o_rsp_valid.

Parameters:
DATA_WIDTH, 32, memory data bus width; 32 or 64 only. MASK_W = DATA_WIDTH/8.
ADDR_WIDTH, 32, byte address width.
GNT_TIMEOUT, 256, max cycles in ISSUE waiting for i_mem_gnt; 0 disables timeout.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset
i_req_valid  in  1  hart presents access
o_req_ready  out  1  bridge accepts access (IDLE only)
i_req_wen  in  1  1=store, 0=load
i_req_addr  in  ADDR_WIDTH  byte address
i_req_size  in  2  0=byte,1=half,2=word,3=dword (dword legal only when DATA_WIDTH=64)
i_req_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
i_req_wdata  in  DATA_WIDTH  store data, right-justified
o_rsp_valid  out  1  response available
i_rsp_ready  in  1  hart consumes response
o_rsp_rdata  out  DATA_WIDTH  extended load data (0 for stores/traps)
o_rsp_trap  out  1  misaligned address or illegal size
o_rsp_err  out  1  grant timeout or memory error
o_mem_req  out  1  memory request
i_mem_gnt  in  1  memory accepts request
o_mem_addr  out  ADDR_WIDTH  address aligned to MASK_W bytes
o_mem_wen  out  1  write request
o_mem_wdata  out  DATA_WIDTH  store data shifted to byte lanes
o_mem_mask  out  MASK_W  active byte lanes
i_mem_rvalid  in  1  response beat (reads and write acks)
i_mem_rdata  in  DATA_WIDTH  read data, full bus word
i_mem_err  in  1  bus error, qualified by i_mem_rvalid

Behaviour:
- Reset: one clock i_clk; reset is asynchronous and active-low (i_rst_n); takes effect immediately, regardless of state. State=IDLE, timeout counter=0, all outputs 0 except o_req_ready=1. In-flight memory transaction is abandoned.
- States IDLE, ISSUE, WAIT, RESP.
- IDLE: o_req_ready=1. On i_req_valid, latch all request fields.
  - Misaligned (addr mod 2^size != 0) or size=3 with DATA_WIDTH=32 -> RESP with trap=1, err=0, rdata=0. No memory access.
  - Otherwise -> ISSUE.
- ISSUE: o_mem_req=1; addr/wen/wdata/mask held stable until grant.
  - Mask = ((1<<2^size)-1) << off, where off = addr mod MASK_W. Wdata = req_wdata << 8*off.
  - i_mem_gnt=1 -> WAIT on the next edge; o_mem_req drops.
  - Counter increments each ISSUE cycle without grant. On reaching GNT_TIMEOUT -> RESP with err=1, o_mem_req drops. A grant on the same cycle as the timeout wins.
- WAIT: o_mem_req=0. Capture on i_mem_rvalid.
  - Loads: rdata = (i_mem_rdata >> 8*off), truncated to 2^size bytes, then sign- or zero-extended to DATA_WIDTH. Unmasked lanes are ignored.
  - Stores: rdata=0.
  - err=i_mem_err. When err=1, rdata=0.
  - -> RESP. No timeout in WAIT; the memory guarantees a response after grant.
- RESP: o_rsp_valid=1; rdata/trap/err held stable until i_rsp_ready. On ready -> IDLE.
  - New requests are not accepted in the same cycle. Minimum throughput is one access per 4 cycles.
- i_mem_rvalid outside WAIT is ignored.
- i_mem_gnt outside ISSUE is ignored.
- Minimum latency, req accept to o_rsp_valid: 3 edges (grant in first ISSUE cycle, rvalid in first WAIT cycle).
- o_rsp_trap and o_rsp_err are never both 1.

Test Plan:
- DATA_WIDTH=32, load size=1 unsigned=0, addr=0x1002, mem word 0x8001_1234, gnt and rvalid immediate -> o_mem_addr=0x1000, mask=0b1100, rsp rdata=0xFFFF_8001, trap=0, valid 3 cycles after accept.
- Store size=0, addr=0x2003, wdata=0x0000_00AB -> o_mem_mask=0b1000, o_mem_wdata=0xAB00_0000, o_mem_wen=1; ack -> rdata=0, err=0.
- Load word addr=0x1006 -> o_rsp_trap=1 next cycle, o_mem_req never asserted; size=3 with DATA_WIDTH=32 -> trap=1.
- GNT_TIMEOUT=4, gnt held 0 -> o_mem_req high exactly 4 cycles, then o_rsp_err=1, rdata=0; o_rsp_valid held while i_rsp_ready=0 for 5 cycles; returns to IDLE on ready.
- DATA_WIDTH=64, lwu addr=0x14, rdata=0x9000_0001_0000_0000 -> addr=0x10, mask=0xF0, rdata=0x0000_0000_9000_0001; rvalid with i_mem_err=1 -> err=1, rdata=0.
- i_rst_n pulsed low asynchronously mid-WAIT -> outputs clear before the next edge; o_req_ready=1; a stray rvalid afterwards produces no response.
